// File: rtl/mux_scan_pkg.sv
// Shared definitions for the scanning N:1 multiplexer: state encoding and
// a width helper that never returns fewer than one bit.
package mux_scan_pkg;

   localparam logic [0:0] ST_MANUAL = 1'b0;
   localparam logic [0:0] ST_SCAN   = 1'b1;

   // $clog2(2) is 1 but $clog2(1) is 0; the floor keeps every select and counter at least 1 bit wide
   function automatic int clog2_min1(input int v);
      return (v <= 2) ? 1 : $clog2(v);
   endfunction

endpackage

// File: rtl/mux_nto1_scan_reg_if.sv
// Bus between the channel sources/control and the scanning multiplexer.
// There is no handshake: inputs are sampled every rising edge, and outputs are registered and valid every cycle.
interface mux_nto1_scan_reg_if
   import mux_scan_pkg::*;
#(
   parameter int WIDTH = 1,
   parameter int N     = 4,
   parameter int SEL_W = clog2_min1(N)
);

   logic [N*WIDTH-1:0] D;
   logic [SEL_W-1:0]   S;
   logic               LOAD;
   logic               MODE;
   logic               HOLD;
   logic [WIDTH-1:0]   Z;
   logic               VALID;
   logic [SEL_W-1:0]   SEL_CUR;
   logic               SWITCH;
   logic               ERR;

   modport master (
      output D, S, LOAD, MODE, HOLD,
      input  Z, VALID, SEL_CUR, SWITCH, ERR
   );

   modport slave (
      input  D, S, LOAD, MODE, HOLD,
      output Z, VALID, SEL_CUR, SWITCH, ERR
   );

endinterface

// File: rtl/mux_nto1_scan_reg_dwell_counter.sv
// Dwell timer for scan mode: counts 0..DWELL-1 while enabled and wraps.
// o_tc flags the last cycle of a dwell period.
module dwell_counter
   import mux_scan_pkg::*;
#(
   parameter int DWELL = 8
) (
   input  logic CLK,
   input  logic RST_N,
   input  logic i_clr,
   input  logic i_en,
   output logic o_tc
);

   localparam int CNT_W = clog2_min1(DWELL);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

   logic [CNT_W-1:0] r_cnt;

   assign o_tc = (r_cnt == LAST);

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= o_tc ? '0 : r_cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/mux_nto1_scan_reg.sv
// Registered N:1 multiplexer with manual (strobed) or auto-scan selection.
// Every select change blanks VALID for the cycle in which the new channel first appears on Z.
module mux_nto1_scan_reg
   import mux_scan_pkg::*;
#(
   parameter  int WIDTH = 1,
   parameter  int N     = 4,
   parameter  int DWELL = 8,
   localparam int SEL_W = clog2_min1(N)
) (
   input logic                CLK,
   input logic                RST_N,
   mux_nto1_scan_reg_if.slave bus
);

   localparam logic [SEL_W:0]   N_LIM = (SEL_W + 1)'(N);
   localparam logic [SEL_W-1:0] LAST  = SEL_W'(N - 1);

   logic [0:0]       r_state;
   logic [SEL_W-1:0] r_sel;
   logic [WIDTH-1:0] r_z;
   logic             r_valid;
   logic             r_switch;
   logic             r_err;

   logic [SEL_W-1:0] w_sel_next;
   logic [WIDTH-1:0] w_z_next;
   logic             w_err_next;
   logic             w_change;
   logic             w_cnt_en;
   logic             w_cnt_clr;
   logic             w_tc;

   dwell_counter #(.DWELL(DWELL)) u_dwell (
      .CLK   (CLK),
      .RST_N (RST_N),
      .i_clr (w_cnt_clr),
      .i_en  (w_cnt_en),
      .o_tc  (w_tc)
   );

   // Manual-state strobes only count while MODE stays 0, so a switch into scan drops LOAD
   always_comb begin
      w_sel_next = r_sel;
      w_err_next = 1'b0;
      if (r_state == ST_MANUAL) begin
         if (!bus.MODE && bus.LOAD) begin
            if ({1'b0, bus.S} < N_LIM) begin
               w_sel_next = bus.S;
            end else begin
               w_err_next = 1'b1;
            end
         end
      end else if (!bus.HOLD && w_tc) begin
         w_sel_next = (r_sel == LAST) ? '0 : r_sel + SEL_W'(1);
      end
   end

   assign w_change  = (w_sel_next != r_sel);
   assign w_cnt_clr = (r_state == ST_MANUAL);
   assign w_cnt_en  = (r_state == ST_SCAN) && !bus.HOLD;

   always_comb begin
      w_z_next = '0;
      for (int k = 0; k < N; k++) begin
         if (w_sel_next == SEL_W'(k)) begin
            w_z_next = bus.D[k*WIDTH +: WIDTH];
         end
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state  <= ST_MANUAL;
         r_sel    <= '0;
         r_z      <= '0;
         r_valid  <= 1'b0;
         r_switch <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_state  <= bus.MODE ? ST_SCAN : ST_MANUAL;
         r_sel    <= w_sel_next;
         r_z      <= w_z_next;
         r_valid  <= !w_change;
         r_switch <= w_change;
         r_err    <= w_err_next;
      end
   end

   assign bus.Z       = r_z;
   assign bus.VALID   = r_valid;
   assign bus.SEL_CUR = r_sel;
   assign bus.SWITCH  = r_switch;
   assign bus.ERR     = r_err;

endmodule

// File: tb/tb_mux_nto1_scan_reg.sv
// Bench for mux_nto1_scan_reg (N=3, WIDTH=8, DWELL=4): directed scenarios then
// random traffic, every cycle compared against a channel/dwell-time model.
module tb_mux_nto1_scan_reg;
   import mux_scan_pkg::*;

   localparam int WIDTH = 8;
   localparam int N     = 3;
   localparam int DWELL = 4;
   localparam int SEL_W = clog2_min1(N);

   logic CLK   = 1'b0;
   logic RST_N = 1'b0;

   mux_nto1_scan_reg_if #(.WIDTH(WIDTH), .N(N), .SEL_W(SEL_W)) bus ();

   mux_nto1_scan_reg #(.WIDTH(WIDTH), .N(N), .DWELL(DWELL)) dut (
      .CLK   (CLK),
      .RST_N (RST_N),
      .bus   (bus)
   );

   always #5 CLK = ~CLK;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model: which channel is shown, and how many cycles remain on it
   bit               m_scan;
   int               m_sel;
   int               m_left;
   logic [WIDTH-1:0] e_z;
   bit               e_valid, e_sw, e_err;

   function automatic logic [WIDTH-1:0] chan(input logic [N*WIDTH-1:0] d, input int k);
      return d[k*WIDTH +: WIDTH];
   endfunction

   task automatic model_reset();
      m_scan = 0; m_sel = 0; m_left = DWELL;
      e_z = '0; e_valid = 0; e_sw = 0; e_err = 0;
   endtask

   task automatic model_step();
      int nxt;
      nxt   = m_sel;
      e_err = 0;
      if (!m_scan) begin
         if (!bus.MODE && bus.LOAD) begin
            if (int'(bus.S) < N) nxt = int'(bus.S);
            else e_err = 1;
         end
         m_left = DWELL;
      end else if (!bus.HOLD) begin
         m_left--;
         if (m_left == 0) begin
            nxt    = (m_sel + 1) % N;
            m_left = DWELL;
         end
      end
      e_sw    = (nxt != m_sel);
      e_valid = !e_sw;
      e_z     = chan(bus.D, nxt);
      m_sel   = nxt;
      m_scan  = bus.MODE;
   endtask

   task automatic check_outputs(input string tag);
      check_eq({tag, ".z"},      32'(bus.Z),       32'(e_z));
      check_eq({tag, ".valid"},  32'(bus.VALID),   32'(e_valid));
      check_eq({tag, ".sel"},    32'(bus.SEL_CUR), 32'(m_sel));
      check_eq({tag, ".switch"}, 32'(bus.SWITCH),  32'(e_sw));
      check_eq({tag, ".err"},    32'(bus.ERR),     32'(e_err));
   endtask

   task automatic check_zero(input string tag);
      check_eq({tag, ".z"},      32'(bus.Z),       32'd0);
      check_eq({tag, ".valid"},  32'(bus.VALID),   32'd0);
      check_eq({tag, ".sel"},    32'(bus.SEL_CUR), 32'd0);
      check_eq({tag, ".switch"}, 32'(bus.SWITCH),  32'd0);
      check_eq({tag, ".err"},    32'(bus.ERR),     32'd0);
   endtask

   task automatic step(input string tag);
      @(posedge CLK);
      model_step();
      #1;
      check_outputs(tag);
   endtask

   // Asserted away from any clock edge so the clear must be asynchronous
   task automatic do_reset(input string tag);
      RST_N = 1'b0;
      #1;
      check_zero(tag);
      model_reset();
      @(negedge CLK);
      RST_N = 1'b1;
   endtask

   task automatic wait_switch(input string tag, input int max_cyc, output int taken);
      taken = 0;
      for (int i = 0; i < max_cyc; i++) begin
         step(tag);
         taken++;
         if (bus.SWITCH) return;
      end
      check_eq({tag, ".timeout"}, 32'd0, 32'd1);
   endtask

   int sel_log[$];
   int taken;

   initial begin
      bus.D    = {8'h33, 8'h22, 8'h11};
      bus.S    = '0;
      bus.LOAD = 1'b0;
      bus.MODE = 1'b0;
      bus.HOLD = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      check_zero("por");
      model_reset();
      @(negedge CLK);
      RST_N = 1'b1;

      step("rst_rel");
      check_eq("rst_rel.z_lit", 32'(bus.Z), 32'h11);
      check_eq("rst_rel.valid_lit", 32'(bus.VALID), 32'd1);

      bus.LOAD = 1'b1; bus.S = 2'd2;
      step("load2");
      bus.LOAD = 1'b0;
      check_eq("load2.z_lit", 32'(bus.Z), 32'h33);
      check_eq("load2.switch_lit", 32'(bus.SWITCH), 32'd1);
      step("load2_next");
      check_eq("load2_next.valid_lit", 32'(bus.VALID), 32'd1);

      bus.LOAD = 1'b1; bus.S = 2'd3;
      step("bad_sel");
      bus.LOAD = 1'b0;
      check_eq("bad_sel.err_lit", 32'(bus.ERR), 32'd1);
      check_eq("bad_sel.sel_lit", 32'(bus.SEL_CUR), 32'd2);
      step("bad_sel_next");

      bus.LOAD = 1'b1; bus.S = 2'd2;
      step("same_sel");
      check_eq("same_sel.switch_lit", 32'(bus.SWITCH), 32'd0);
      bus.S = 2'd0;
      step("back0");
      bus.LOAD = 1'b0;

      // Auto-scan: one entry cycle, then a switch every DWELL cycles
      bus.MODE = 1'b1;
      for (int i = 0; i < 1 + 3 * DWELL; i++) begin
         step("scan");
         if (bus.SWITCH) sel_log.push_back(int'(bus.SEL_CUR));
      end
      check_eq("scan.n_switch", 32'(sel_log.size()), 32'd3);
      if (sel_log.size() == 3) begin
         check_eq("scan.seq0", 32'(sel_log[0]), 32'd1);
         check_eq("scan.seq1", 32'(sel_log[1]), 32'd2);
         check_eq("scan.seq2", 32'(sel_log[2]), 32'd0);
      end

      step("pre_hold");
      bus.HOLD = 1'b1;
      for (int i = 0; i < 10; i++) begin
         bus.D = (N*WIDTH)'($urandom);
         step("hold");
         check_eq("hold.sel_lit", 32'(bus.SEL_CUR), 32'd0);
      end
      bus.HOLD = 1'b0;
      wait_switch("hold_resume", 2 * DWELL, taken);
      check_eq("hold_resume.cycles", 32'(taken), 32'(DWELL - 1));

      // Mode handoff while channel 1 is shown
      bus.MODE = 1'b0;
      step("to_manual");
      check_eq("to_manual.sel_lit", 32'(bus.SEL_CUR), 32'd1);
      bus.LOAD = 1'b1; bus.S = 2'd1;
      step("load_same");
      bus.LOAD = 1'b0;
      check_eq("load_same.switch_lit", 32'(bus.SWITCH), 32'd0);
      bus.MODE = 1'b1;
      wait_switch("to_scan", 3 * DWELL, taken);
      check_eq("to_scan.cycles", 32'(taken), 32'(DWELL + 1));
      check_eq("to_scan.sel_lit", 32'(bus.SEL_CUR), 32'd2);

      wait_switch("pre_blank", 3 * DWELL, taken);
      do_reset("rst_blank");
      bus.MODE = 1'b0;
      step("after_rst");
      check_eq("after_rst.z_lit", 32'(bus.Z), 32'(chan(bus.D, 0)));

      // Random traffic
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 15) == 0) bus.MODE = ~bus.MODE;
         bus.LOAD = ($urandom_range(0, 3) == 0);
         bus.S    = SEL_W'($urandom_range(0, 3));
         bus.HOLD = ($urandom_range(0, 7) == 0);
         bus.D    = (N*WIDTH)'($urandom);
         if ($urandom_range(0, 399) == 0) do_reset("rand_rst");
         step("rand");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mux_nto1_scan_reg.md
Name: mux_nto1_scan_reg

Overview:
- Parametrised, registered N:1 multiplexer. Generalises the 2:1 select function to N channels of WIDTH bits each.
- Two select modes: manual, where a select value is loaded on a strobe, and auto-scan, where the select rotates through the channels with a programmable dwell time.
- Output is blanked for one cycle on every channel switch, so downstream logic never samples a mixed-source cycle.
- Sits between parallel source buses and a single consumer, for example a display or probe path.

Parameters:
- WIDTH, 1: bits per channel.
- N, 4: channel count, legal range 2..16.
- SEL_W, $clog2(N): select width (derived, do not override).
- DWELL, 8: cycles spent on each channel in scan mode, minimum 2.

Ports:
- CLK  input  1  rising-edge clock
- RST_N  input  1  asynchronous active-low reset
- D  input  N*WIDTH  channel data; channel k occupies bits [k*WIDTH +: WIDTH]
- S  input  SEL_W  manual select value
- LOAD  input  1  strobe: capture S into the select register (manual mode only)
- MODE  input  1  0 = manual, 1 = auto-scan
- HOLD  input  1  in scan mode, freeze the dwell counter and the select
- Z  output  WIDTH  registered selected data
- VALID  output  1  Z is from a settled channel
- SEL_CUR  output  SEL_W  select currently driving Z
- SWITCH  output  1  one-cycle pulse when the select changes
- ERR  output  1  one-cycle pulse when LOAD carries S >= N

Behaviour:
- Reset (asynchronous, RST_N=0): Z=0, VALID=0, SEL_CUR=0, SWITCH=0, ERR=0, dwell counter=0, state=MANUAL.
- States are MANUAL and SCAN. Each cycle the next state follows MODE: 0 gives MANUAL, 1 gives SCAN.
  - Entering SCAN clears the dwell counter and keeps the current select.
  - Entering MANUAL keeps the current select.
- Datapath: Z <= D[sel_next] each cycle, so latency is 1 cycle from D to Z.
- Select change: when sel_next != SEL_CUR, then on that edge:
  - SEL_CUR <= sel_next
  - SWITCH <= 1
  - VALID <= 0
  - Z still loads the new channel.
- VALID returns to 1 on the following cycle if no further change occurs. If neither a change nor a reset occurs, VALID is 1 from the first cycle after reset deasserts.
- MANUAL:
  - LOAD=1 with S<N: sel_next=S.
  - LOAD=1 with S>=N: select unchanged, ERR pulses 1 cycle.
  - LOAD=1 with S equal to SEL_CUR: no SWITCH, no blanking.
  - LOAD=0: select held.
- SCAN:
  - With HOLD=0, the dwell counter increments each cycle.
  - When the counter equals DWELL-1: counter <= 0 and sel_next = (SEL_CUR == N-1) ? 0 : SEL_CUR+1. Wrap-around N-1 to 0 applies for non-power-of-two N.
  - HOLD=1 freezes the counter and the select. Z keeps tracking D of the current channel.
  - LOAD and S are ignored in SCAN. ERR never fires in SCAN.
- Simultaneous events:
  - The MODE 0-to-1 transition takes priority over LOAD in the same cycle; LOAD is dropped.
  - MODE 1-to-0 with LOAD in the same cycle: the state is still SCAN this cycle, so LOAD is ignored.
- Reset mid-scan or mid-blanking returns immediately to the reset values listed above. The first post-reset cycle selects channel 0 with no SWITCH pulse.
- All outputs are registered. There are no combinational paths from input to output.

Decomposition:
- Shared package mux_scan_pkg holds:
  - localparam state encoding ST_MANUAL=1'b0, ST_SCAN=1'b1
  - a function clog2_min1 that returns at least 1 bit, so N=2 still yields SEL_W=1.
- One natural sub-module, dwell_counter: a counter with enable, clear and terminal-count output, parametrised by DWELL.
- The channel slice-select stays inline in the top module.

Test Plan:
- Reset and manual select (N=4, WIDTH=8, D={8'h44,8'h33,8'h22,8'h11}, MODE=0):
  - Release reset, expect Z=8'h11, SEL_CUR=0, VALID=1.
  - Pulse LOAD with S=2: the next cycle gives Z=8'h33, SEL_CUR=2, SWITCH=1, VALID=0; the cycle after gives VALID=1, SWITCH=0.
- Illegal select (N=3): LOAD with S=3 gives ERR=1 for one cycle; SEL_CUR unchanged; no SWITCH.
- Auto-scan wrap (N=3, DWELL=4, MODE=1): SEL_CUR runs 0,1,2,0 with changes every 4 cycles; SWITCH pulses exactly at each change; VALID=0 only on the switch cycles.
- HOLD in scan: assert HOLD for 10 cycles mid-dwell, then release. SEL_CUR stays frozen during HOLD; the remaining dwell count resumes from where it stopped; Z follows a changing D on the held channel with 1-cycle latency.
- Mode handoff:
  - Switch to MODE=0 while SEL_CUR=1: the select holds at 1.
  - LOAD with S=1 gives no SWITCH.
  - Switch back to MODE=1: a full DWELL elapses before advancing to 2.
- Async reset mid-blank: drop RST_N on the cycle where SWITCH=1. All outputs clear immediately, without waiting for a clock edge. After release, Z=D[0], with no SWITCH and no ERR.
